fabric_config_sequencer: RTL and testbench

//   Streams configuration bitstreams into the per-column set/shift chains of the fabric.

---
 rtl/fabric_cfg_pkg.sv | 25 ++
 rtl/cfg_crc16_serial.sv | 36 +++
 rtl/fabric_config_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fabric_config_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration sequencer and the fabric top.
package fabric_cfg_pkg;

  localparam int DEF_NUM_COLS = 3;
  localparam int DEF_WORD_W   = 32;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_e;

  // One CRC-16-CCITT step for a single serial bit, MSB-first register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with clear and enable; crc_next is the value after this cycle.
module cfg_crc16_serial
  import fabric_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc_next
);

  logic [15:0] crc_r;

  // next CRC value: clear wins over accumulate
  always_comb begin
    crc_next = crc_r;
    if (clr) begin
      crc_next = CRC_INIT;
    end else if (en) begin
      crc_next = crc16_step(crc_r, din);
    end else begin
      crc_next = crc_r;
    end
  end

  // CRC register
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= CRC_INIT;
    end else begin
      crc_r <= crc_next;
    end
  end

endmodule

// File: rtl/fabric_config_sequencer.sv
// Serialises configuration words LSB-first into one fabric column's shift chain, then pulses its set line.
// Optional CRC check of the shifted stream is enabled by defining CFG_CRC_EN.
module fabric_config_sequencer
  import fabric_cfg_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS,
  parameter int COL_W    = 2,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int LEN_W    = 16,
  parameter int CRC_W    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COL_W-1:0]    cmd_col,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [CRC_W-1:0]    cmd_crc,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                abort,
  output logic                cen,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  cfg_state_e          state_r, state_s;
  logic [COL_W-1:0]    col_r, col_s;
  logic [LEN_W-1:0]    rem_r, rem_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [WORD_W-1:0]   shreg_r, shreg_s;
  logic                err_s, cen_s, busy_s, done_s, crc_ok_s;
  logic [NUM_COLS-1:0] shift_s, set_s;

  assign cmd_ready  = (state_r == ST_IDLE);
  assign word_ready = (state_r == ST_LOAD);

`ifdef CFG_CRC_EN
  logic [CRC_W-1:0] crc_exp_r;
  logic [CRC_W-1:0] crc_next_s;

  // expected CRC captured with the command
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      crc_exp_r <= {CRC_W{1'b0}};
    end else if (state_r == ST_IDLE && cmd_valid) begin
      crc_exp_r <= cmd_crc;
    end else begin
      crc_exp_r <= crc_exp_r;
    end
  end

  cfg_crc16_serial u_crc (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clr      (state_r == ST_IDLE && cmd_valid),
    .en       (state_r == ST_SHIFT),
    .din      (shreg_r[0]),
    .crc_next (crc_next_s)
  );

  assign crc_ok_s = (crc_next_s == crc_exp_r);
`else
  logic unused_crc_s;
  assign unused_crc_s = ^cmd_crc;
  assign crc_ok_s     = 1'b1;
`endif

  // next-state, datapath and next-output decode
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    rem_s   = rem_r;
    cnt_s   = cnt_r;
    shreg_s = shreg_r;
    err_s   = err;
    if (abort && state_r != ST_IDLE) begin
      // partial bits stay in the chain; a word handshaking this cycle is simply dropped
      state_s = ST_IDLE;
      err_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            col_s = cmd_col;
            rem_s = cmd_len;
            err_s = 1'b0;
            if (int'(cmd_col) >= NUM_COLS || cmd_len == {LEN_W{1'b0}}) begin
              err_s   = 1'b1;
              state_s = ST_IDLE;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            shreg_s = word_data;
            cnt_s   = (rem_r >= LEN_W'(WORD_W)) ? CNT_W'(WORD_W) : CNT_W'(rem_r);
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          shreg_s = shreg_r >> 1;
          cnt_s   = cnt_r - CNT_W'(1);
          rem_s   = rem_r - LEN_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_s = (rem_r == LEN_W'(1)) ? ST_SET : ST_LOAD;
          end else begin
            state_s = ST_SHIFT;
          end
        end
        ST_SET: begin
          if (crc_ok_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_IDLE;
            err_s   = 1'b1;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end

    // outputs are registered, so they are decoded from the state being entered
    cen_s  = (state_s == ST_SHIFT) || (state_s == ST_SET);
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    if (state_s == ST_SHIFT) begin
      shift_s = NUM_COLS'(shreg_s[0]) << col_s;
    end else begin
      shift_s = {NUM_COLS{1'b0}};
    end
    if (state_s == ST_SET && crc_ok_s) begin
      set_s = NUM_COLS'(1'b1) << col_s;
    end else begin
      set_s = {NUM_COLS{1'b0}};
    end
  end

  // state, datapath and output registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= ST_IDLE;
      col_r     <= {COL_W{1'b0}};
      rem_r     <= {LEN_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      shreg_r   <= {WORD_W{1'b0}};
      cen       <= 1'b0;
      shift_out <= {NUM_COLS{1'b0}};
      set_out   <= {NUM_COLS{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      col_r     <= col_s;
      rem_r     <= rem_s;
      cnt_r     <= cnt_s;
      shreg_r   <= shreg_s;
      cen       <= cen_s;
      shift_out <= shift_s;
      set_out   <= set_s;
      busy      <= busy_s;
      done      <= done_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_fabric_config_sequencer.sv
// Randomised self-checking bench for fabric_config_sequencer against a bit-list reference model.
module tb_fabric_config_sequencer;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_col = 2'd0;
  logic [15:0] cmd_len = 16'd0;
  logic [15:0] cmd_crc = 16'd0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic [31:0] word_data = 32'd0;
  logic        abort = 1'b0;
  logic        cen;
  logic [2:0]  shift_out;
  logic [2:0]  set_out;
  logic        busy;
  logic        done;
  logic        err;

  fabric_config_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_len(cmd_len), .cmd_crc(cmd_crc), .word_valid(word_valid),
    .word_ready(word_ready), .word_data(word_data), .abort(abort), .cen(cen),
    .shift_out(shift_out), .set_out(set_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // observation state filled by the monitor
  logic        obs_bits[$];
  logic [31:0] words[$];
  int set_cnt, set_cyc, cen_cnt, done_cnt, done_cyc, first_cyc, last_cyc, stray, mon_col;
  logic [2:0] set_val;
  bit seen;

  always @(negedge clk) begin
    logic [2:0] mask;
    mask = ~(3'b001 << mon_col);
    if (set_out != 3'b000) begin set_cnt++; set_val = set_out; set_cyc = cyc; end
    if (cen) begin
      cen_cnt++;
      if (set_out == 3'b000) begin
        obs_bits.push_back(shift_out[mon_col]);
        if (!seen) begin first_cyc = cyc; seen = 1'b1; end
        last_cyc = cyc;
      end
    end
    if ((shift_out & mask) != 3'b000 || (set_out & mask) != 3'b000 || (!cen && shift_out != 3'b000)) stray++;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference: bit i of the stream is bit (i mod 32) of word (i div 32), LSB first
  function automatic logic exp_bit(int i);
    logic [31:0] w;
    w = words[i / 32];
    return w[i % 32];
  endfunction

  function automatic int bad_bits(int n);
    int nb = 0;
    for (int i = 0; i < obs_bits.size() && i < n; i++) if (obs_bits[i] !== exp_bit(i)) nb++;
    return nb;
  endfunction

  task automatic clear_mon(input int col);
    obs_bits.delete();
    set_cnt = 0; cen_cnt = 0; done_cnt = 0; stray = 0; seen = 1'b0;
    set_cyc = -1; done_cyc = -1; first_cyc = -1; last_cyc = -1; set_val = 3'b000;
    mon_col = col;
  endtask

  task automatic send_cmd(input int col, input int len, input logic [15:0] crc,
                          input bit pre, input logic [31:0] w0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_col = col[1:0]; cmd_len = len[15:0]; cmd_crc = crc;
    if (pre) begin word_valid = 1'b1; word_data = w0; end
    @(negedge clk);
    acc_cyc = cyc;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready: got %b need 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_words(input bit pre, input int gapmax);
    bit hs;
    int t;
    for (int i = 0; i < words.size(); i++) begin
      if (!(pre && i == 0)) begin
        word_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) begin @(posedge clk); #1; end
        word_valid = 1'b1; word_data = words[i];
      end
      hs = 1'b0; t = 0;
      while (!hs && t < 200) begin @(negedge clk); hs = word_ready; @(posedge clk); #1; t++; end
      word_valid = 1'b0;
      checks++;
      if (!hs) begin errors++; $display("FAIL word_handshake: word %0d not taken in %0d cycles", i, t); end
    end
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (done_cnt == 0 && t < bound) begin @(negedge clk); #1; t++; end
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", bound); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, word_ready, cen, shift_out, set_out, busy, done, err} !== 12'b1000_0000_0000)
      begin errors++; $display("FAIL reset_outputs: got %b need 100000000000",
        {cmd_ready, word_ready, cen, shift_out, set_out, busy, done, err}); end
    @(posedge clk); #1 wb_rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, cen, err} !== 4'b1000) begin errors++;
      $display("FAIL idle_after_reset: got %b need 1000", {cmd_ready, busy, cen, err}); end
  endtask

  task automatic test_single_word();
    words = '{32'h000000A5};
    clear_mon(1);
    send_cmd(1, 8, 16'h0000, 1'b1, words[0]);
    feed_words(1'b1, 0);
    wait_done(100);
    checks++;
    if (obs_bits.size() != 8 || bad_bits(8) != 0) begin errors++;
      $display("FAIL a5_bits: got %0d bits (%0d wrong) need 8", obs_bits.size(), bad_bits(8)); end
    checks++;
    if (first_cyc - acc_cyc != 2) begin errors++;
      $display("FAIL a5_latency: got %0d need 2", first_cyc - acc_cyc); end
    checks++;
    if (set_cnt != 1 || set_val !== 3'b010) begin errors++;
      $display("FAIL a5_set: got %0d pulses value %b need 1 x 010", set_cnt, set_val); end
    checks++;
    if (set_cyc != last_cyc + 1 || done_cyc != set_cyc + 1 || done_cnt != 1) begin errors++;
      $display("FAIL a5_timing: last %0d set %0d done %0d (x%0d)", last_cyc, set_cyc, done_cyc, done_cnt); end
    checks++;
    if (cen_cnt != 9 || stray != 0 || err !== 1'b0) begin errors++;
      $display("FAIL a5_misc: cen %0d need 9, stray %0d need 0, err %b need 0", cen_cnt, stray, err); end
  endtask

  task automatic test_stall();
    int col, t, stall_bad;
    bit hs;
    col = $urandom_range(2, 0);
    words = '{32'hFFFFFFFF, 32'h0000001F};
    clear_mon(col);
    send_cmd(col, 40, 16'h0000, 1'b1, words[0]);
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin @(negedge clk); hs = word_ready; @(posedge clk); #1; t++; end
    word_valid = 1'b0;
    t = 0;
    @(negedge clk);
    while (!word_ready && t < 100) begin @(negedge clk); t++; end
    stall_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (cen !== 1'b0 || word_ready !== 1'b1) stall_bad++;
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_cen: %0d of 5 stall cycles wrong", stall_bad); end
    @(posedge clk); #1;
    word_valid = 1'b1; word_data = words[1];
    hs = 1'b0; t = 0;
    while (!hs && t < 50) begin @(negedge clk); hs = word_ready; @(posedge clk); #1; t++; end
    word_valid = 1'b0;
    wait_done(100);
    checks++;
    if (obs_bits.size() != 40 || bad_bits(40) != 0) begin errors++;
      $display("FAIL stall_bits: got %0d bits (%0d wrong) need 40", obs_bits.size(), bad_bits(40)); end
    checks++;
    if (cen_cnt != 41 || set_cnt != 1 || set_val !== (3'b001 << col)) begin errors++;
      $display("FAIL stall_set: cen %0d need 41, set %0d x %b", cen_cnt, set_cnt, set_val); end
  endtask

  task automatic test_bad_cmd();
    int act;
    clear_mon(3);
    send_cmd(3, 8, 16'h0000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL badcol_err: err %b busy %b need 1 0", err, busy); end
    act = 0;
    repeat (4) begin @(negedge clk); if (busy || cen || set_out != 3'b000 || shift_out != 3'b000) act++; end
    checks++;
    if (act != 0 || done_cnt != 0) begin errors++;
      $display("FAIL badcol_quiet: %0d active cycles, %0d done", act, done_cnt); end
    clear_mon(0);
    send_cmd(0, 0, 16'h0000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL zerolen_err: err %b busy %b need 1 0", err, busy); end
    words = '{$urandom()};
    clear_mon(0);
    send_cmd(0, 5, 16'h0000, 1'b1, words[0]);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL err_clear: err %b busy %b need 0 1", err, busy); end
    feed_words(1'b1, 0);
    wait_done(100);
    checks++;
    if (obs_bits.size() != 5 || bad_bits(5) != 0 || set_val !== 3'b001) begin errors++;
      $display("FAIL after_err_load: %0d bits, set %b", obs_bits.size(), set_val); end
  endtask

  task automatic test_abort();
    int col, t;
    col = $urandom_range(2, 0);
    words = '{$urandom()};
    clear_mon(col);
    send_cmd(col, 32, 16'h0000, 1'b1, words[0]);
    t = 0;
    while (obs_bits.size() < 10 && t < 100) begin @(negedge clk); #1; t++; end
    abort = 1'b1;
    word_valid = 1'b0;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++;
    if (cen !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin errors++;
      $display("FAIL abort_next: cen %b busy %b err %b need 0 0 1", cen, busy, err); end
    repeat (40) @(negedge clk);
    checks++;
    if (set_cnt != 0 || done_cnt != 0 || err !== 1'b1) begin errors++;
      $display("FAIL abort_quiet: set %0d done %0d err %b", set_cnt, done_cnt, err); end
    checks++;
    if (obs_bits.size() != 10 || bad_bits(10) != 0) begin errors++;
      $display("FAIL abort_bits: got %0d bits (%0d wrong) need 10", obs_bits.size(), bad_bits(10)); end
  endtask

  task automatic test_reset_mid();
    int col, len, t;
    col = $urandom_range(2, 0);
    words = '{$urandom(), $urandom()};
    clear_mon(col);
    send_cmd(col, 64, 16'h0000, 1'b1, words[0]);
    t = 0;
    while (obs_bits.size() < 5 && t < 100) begin @(negedge clk); #1; t++; end
    wb_rst_i = 1'b1; word_valid = 1'b0;
    @(posedge clk); #1 wb_rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, word_ready, cen, shift_out, set_out, busy, done, err} !== 12'b1000_0000_0000)
      begin errors++; $display("FAIL midreset_outputs: got %b need 100000000000",
        {cmd_ready, word_ready, cen, shift_out, set_out, busy, done, err}); end
    col = $urandom_range(2, 0);
    len = $urandom_range(32, 1);
    words = '{$urandom()};
    clear_mon(col);
    send_cmd(col, len, 16'h0000, 1'b1, words[0]);
    feed_words(1'b1, 0);
    wait_done(100);
    checks++;
    if (obs_bits.size() != len || bad_bits(len) != 0 || set_cnt != 1 || set_val !== (3'b001 << col))
      begin errors++; $display("FAIL midreset_fresh: %0d bits need %0d, set %0d x %b",
        obs_bits.size(), len, set_cnt, set_val); end
  endtask

  task automatic test_random_back_to_back();
    int col, len;
    bit pre;
    for (int n = 0; n < 8; n++) begin
      col = $urandom_range(2, 0);
      len = $urandom_range(100, 1);
      pre = $urandom_range(1, 0);
      words.delete();
      for (int w = 0; w < (len + 31) / 32; w++) words.push_back($urandom());
      clear_mon(col);
      send_cmd(col, len, 16'h0000, pre, words[0]);
      feed_words(pre, 3);
      wait_done(400);
      checks++;
      if (obs_bits.size() != len || bad_bits(len) != 0) begin errors++;
        $display("FAIL rnd_bits[%0d]: got %0d bits (%0d wrong) need %0d", n, obs_bits.size(), bad_bits(len), len); end
      checks++;
      if (set_cnt != 1 || set_val !== (3'b001 << col) || done_cnt != 1 || err !== 1'b0) begin errors++;
        $display("FAIL rnd_set[%0d]: set %0d x %b done %0d err %b", n, set_cnt, set_val, done_cnt, err); end
      checks++;
      if (cen_cnt != len + 1 || stray != 0) begin errors++;
        $display("FAIL rnd_cen[%0d]: cen %0d need %0d, stray %0d", n, cen_cnt, len + 1, stray); end
    end
  endtask

`ifdef CFG_CRC_EN
  task automatic test_crc();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      c = c ^ (16'(exp_bit_a5(i)) << 15);
      if (c[15]) c = (c << 1) ^ 16'h1021; else c = c << 1;
    end
    for (int k = 0; k < 2; k++) begin
      words = '{32'h000000A5};
      clear_mon(1);
      send_cmd(1, 8, (k == 0) ? c : (c ^ 16'h0001), 1'b1, words[0]);
      feed_words(1'b1, 0);
      repeat (20) @(negedge clk);
      checks++;
      if (k == 0 && (set_cnt != 1 || done_cnt != 1 || err !== 1'b0)) begin errors++;
        $display("FAIL crc_good: set %0d done %0d err %b", set_cnt, done_cnt, err); end
      if (k == 1 && (set_cnt != 0 || done_cnt != 0 || err !== 1'b1)) begin errors++;
        $display("FAIL crc_bad: set %0d done %0d err %b", set_cnt, done_cnt, err); end
    end
  endtask

  function automatic logic exp_bit_a5(int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction
`endif

  initial begin
    clear_mon(0);
    test_reset();
    test_single_word();
    test_stall();
    test_bad_cmd();
    test_abort();
    test_reset_mid();
    test_random_back_to_back();
`ifdef CFG_CRC_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
